coeff_mac_accumulator: RTL and testbench

Consumer end of the circular-shift-register coefficient stream.
- Receives serial 2-bit signed coefficients, one per beat, from the rotating coefficient register pair.
- Multiplies each coefficient by a per-beat signed multiplicand and accumulates into n result accumulators.
- After n rows of n beats, the finished result polynomial is streamed out one coefficient per handshake.

---
 rtl/coeff_mac_accumulator.sv | 154 +++++++++++++++
 tb/tb_coeff_mac_accumulator.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_mac_accumulator.sv
// Consumer end of the rotating coefficient stream. It multiply-accumulates serial
// 2-bit signed coefficients into N accumulators, then streams out the result polynomial.
module coeff_mac_accumulator #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          coeff_valid,
  input  logic [1:0]    coeff,
  input  logic [BW-1:0] b_coeff,
  input  logic          res_ready,
  output logic          busy,
  output logic          res_valid,
  output logic [W-1:0]  res_data,
  output logic          res_last
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_row, w_row_nxt;
  logic [CW-1:0] r_col, w_col_nxt;
  logic [CW-1:0] r_idx, w_idx_nxt;
  logic [CW-1:0] w_tgt;
  logic [W-1:0]  r_acc     [N];
  logic [W-1:0]  w_acc_nxt [N];

  logic          r_busy, w_busy_nxt;
  logic          r_res_valid, w_res_valid_nxt;
  logic [W-1:0]  r_res_data, w_res_data_nxt;
  logic          r_res_last, w_res_last_nxt;

  // The 2-bit code is already two's complement (10 = -2), so both operands
  // are sign-extended to BW+2 bits, which holds every possible product.
  function automatic logic [W-1:0] beat_term(input logic [1:0] c, input logic [BW-1:0] b);
    logic signed [BW+1:0] p;
    p = $signed({{BW{c[1]}}, c}) * $signed({{2{b[BW-1]}}, b});
    return W'(p);
  endfunction

  assign w_tgt = LAST - r_col;

  // State register together with the registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_idx       <= '0;
      for (int k = 0; k < N; k++) r_acc[k] <= '0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_idx       <= w_idx_nxt;
      for (int k = 0; k < N; k++) r_acc[k] <= w_acc_nxt[k];
      r_busy      <= w_busy_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_data  <= w_res_data_nxt;
      r_res_last  <= w_res_last_nxt;
    end
  end

  // Next-state logic: accumulation walk and output index
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_idx_nxt   = r_idx;
    w_acc_nxt   = r_acc;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          for (int k = 0; k < N; k++) w_acc_nxt[k] = '0;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_state_nxt = S_ACC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACC: begin
        if (coeff_valid) begin
          w_acc_nxt[w_tgt] = r_acc[w_tgt] + beat_term(coeff, b_coeff);
          if (r_col == LAST) begin
            w_col_nxt = '0;
            if (r_row == LAST) begin
              w_row_nxt   = '0;
              w_idx_nxt   = '0;
              w_state_nxt = S_OUT;
            end else begin
              w_row_nxt = r_row + CW'(1);
            end
          end else begin
            w_col_nxt = r_col + CW'(1);
          end
        end else begin
          w_state_nxt = S_ACC;
        end
      end
      S_OUT: begin
        // res_valid is always high while in OUT, so res_ready alone is the handshake
        if (res_ready) begin
          if (r_idx == LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt = r_idx + CW'(1);
          end
        end else begin
          w_state_nxt = S_OUT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic, evaluated on next-state values so the outputs can be registered
  always_comb begin
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_res_valid_nxt = 1'b0;
    w_res_data_nxt  = '0;
    w_res_last_nxt  = 1'b0;
    if (w_state_nxt == S_OUT) begin
      w_res_valid_nxt = 1'b1;
      w_res_data_nxt  = w_acc_nxt[w_idx_nxt];
      w_res_last_nxt  = (w_idx_nxt == LAST);
    end else begin
      w_res_valid_nxt = 1'b0;
    end
  end

  assign busy      = r_busy;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_last  = r_res_last;

endmodule

// File: tb/tb_coeff_mac_accumulator.sv
// Scoreboard bench: W=8 and W=6 instances share stimulus; a reference model of the
// polynomial accumulation queues expected results and a negedge monitor checks them.
module tb_coeff_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       coeff_valid = 1'b0;
  logic [1:0] coeff = 2'b00;
  logic [3:0] b_coeff = 4'd0;
  logic       res_ready = 1'b0;
  logic       busy8, res_valid8, res_last8;
  logic [7:0] res_data8;
  logic       busy6, res_valid6, res_last6;
  logic [5:0] res_data6;

  typedef struct { int data; bit last; } exp_t;
  exp_t q8[$];
  exp_t q6[$];

  int n_vec = 0;
  int n_err = 0;
  int ready_pct = 100;

  coeff_mac_accumulator #(.N(4), .W(8), .BW(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .coeff_valid(coeff_valid), .coeff(coeff),
    .b_coeff(b_coeff), .res_ready(res_ready), .busy(busy8), .res_valid(res_valid8),
    .res_data(res_data8), .res_last(res_last8));

  coeff_mac_accumulator #(.N(4), .W(6), .BW(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start), .coeff_valid(coeff_valid), .coeff(coeff),
    .b_coeff(b_coeff), .res_ready(res_ready), .busy(busy6), .res_valid(res_valid6),
    .res_data(res_data6), .res_last(res_last6));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Coefficient code table, independent of bit-level tricks.
  function automatic int code_val(input logic [1:0] c);
    case (c)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return -1;
      default: return -2;
    endcase
  endfunction

  function automatic int sval4(input logic [3:0] b);
    return (b >= 4'd8) ? int'(b) - 16 : int'(b);
  endfunction

  // Reference model: beat i of a row adds into coefficient (3 - i%4).
  task automatic push_expected(input logic [1:0] cs[16], input logic [3:0] bs[16]);
    int acc[4];
    exp_t e;
    for (int k = 0; k < 4; k++) acc[k] = 0;
    for (int i = 0; i < 16; i++) acc[3 - (i % 4)] += code_val(cs[i]) * sval4(bs[i]);
    for (int k = 0; k < 4; k++) begin
      e.last = (k == 3);
      e.data = acc[k] & 32'hFF; q8.push_back(e);
      e.data = acc[k] & 32'h3F; q6.push_back(e);
    end
  endtask

  task automatic run_product(input int kind, input int gap_pct, input bit noise, input int abort_at);
    logic [1:0] cs[16];
    logic [3:0] bs[16];
    bit done;
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0: begin cs[i] = 2'b01; bs[i] = 4'd3; end
        1: begin cs[i] = 2'b11; bs[i] = 4'd5; end
        2: begin
          bs[i] = (i < 4) ? 4'd2 : 4'($urandom_range(15));
          case (i)
            0: cs[i] = 2'b01;
            1: cs[i] = 2'b00;
            2: cs[i] = 2'b11;
            3: cs[i] = 2'b10;
            default: cs[i] = 2'b00;
          endcase
        end
        3: begin cs[i] = 2'b10; bs[i] = 4'b1000; end
        default: begin cs[i] = 2'($urandom_range(3)); bs[i] = 4'($urandom_range(15)); end
      endcase
    end
    // start, with a possibly simultaneous beat that must be dropped
    start = 1'b1;
    coeff_valid = 1'($urandom_range(1));
    coeff = 2'($urandom_range(3));
    b_coeff = 4'($urandom_range(15));
    tick;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (abort_at == i) begin
        coeff_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy8", busy8, 0);  chk("rst_valid8", res_valid8, 0);
        chk("rst_data8", res_data8, 0); chk("rst_last8", res_last8, 0);
        chk("rst_busy6", busy6, 0);  chk("rst_valid6", res_valid6, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("post_rst_busy", busy8, 0);
        chk("post_rst_valid", res_valid8, 0);
        return;
      end
      while ($urandom_range(99) < gap_pct) begin
        coeff_valid = 1'b0;
        coeff = 2'($urandom_range(3));
        start = noise ? 1'($urandom_range(1)) : 1'b0;
        tick;
      end
      coeff_valid = 1'b1;
      coeff = cs[i];
      b_coeff = bs[i];
      start = noise ? 1'($urandom_range(1)) : 1'b0;
      tick;
    end
    coeff_valid = 1'b0;
    start = 1'b0;
    push_expected(cs, bs);
    chk("latency_valid8", res_valid8, 1);
    chk("latency_valid6", res_valid6, 1);
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (!busy8 && !busy6 && q8.size() == 0 && q6.size() == 0) done = 1'b1;
      else tick;
    end
    chk("drain_timeout", int'(done), 1);
  endtask

  // Downstream back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      res_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Output monitor: pop on every handshake, and require stability while stalled
  initial begin
    bit   hold8 = 1'b0, hold6 = 1'b0;
    int   hd8 = 0, hd6 = 0, hl8 = 0, hl6 = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold8 = 1'b0;
        hold6 = 1'b0;
      end else begin
        if (hold8) begin
          chk("stall_valid8", res_valid8, 1);
          chk("stall_data8", res_data8, hd8);
          chk("stall_last8", res_last8, hl8);
        end
        if (hold6) begin
          chk("stall_data6", res_data6, hd6);
          chk("stall_last6", res_last6, hl6);
        end
        hold8 = res_valid8 && !res_ready; hd8 = res_data8; hl8 = res_last8;
        hold6 = res_valid6 && !res_ready; hd6 = res_data6; hl6 = res_last6;
        if (res_valid8 && res_ready) begin
          if (q8.size() == 0) chk("unexpected_out8", 1, 0);
          else begin
            e = q8.pop_front();
            chk("res_data8", res_data8, e.data);
            chk("res_last8", res_last8, int'(e.last));
          end
        end
        if (res_valid6 && res_ready) begin
          if (q6.size() == 0) chk("unexpected_out6", 1, 0);
          else begin
            e = q6.pop_front();
            chk("res_data6", res_data6, e.data);
            chk("res_last6", res_last6, int'(e.last));
          end
        end
      end
    end
  end

  initial begin
    #12;
    chk("reset_busy8", busy8, 0);
    chk("reset_valid8", res_valid8, 0);
    chk("reset_data8", res_data8, 0);
    chk("reset_last8", res_last8, 0);
    chk("reset_valid6", res_valid6, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("idle_busy", busy8, 0);
    // idle beats without start must not begin anything
    coeff_valid = 1'b1; coeff = 2'b01; b_coeff = 4'd7;
    tick; tick;
    coeff_valid = 1'b0;
    chk("idle_ignore_beat", busy8, 0);

    ready_pct = 100;
    run_product(0, 0, 1'b0, -1);
    run_product(1, 0, 1'b0, -1);
    run_product(2, 0, 1'b0, -1);
    run_product(3, 0, 1'b0, -1);
    ready_pct = 40;
    run_product(0, 40, 1'b1, -1);
    run_product(2, 30, 1'b1, -1);
    run_product(0, 20, 1'b0, 9);
    run_product(0, 0, 1'b0, -1);
    ready_pct = 60;
    for (int r = 0; r < 20; r++) run_product(4, int'($urandom_range(50)), 1'b1, -1);
    repeat (3) tick;
    chk("queue8_empty", q8.size(), 0);
    chk("queue6_empty", q6.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
